// File: rtl/lavadora_pkg.sv
// Shared washing-machine definitions: spin-controller state encoding and
// the default spin-level durations.
package lavadora_pkg;

  localparam int NUM_NIVELES_DEF = 4;
  localparam int ANCHO_SEG_DEF   = 9;

  // Level 0 occupies the least significant ANCHO_SEG bits.
  localparam logic [NUM_NIVELES_DEF*ANCHO_SEG_DEF-1:0] TIEMPOS_DEF =
    {9'd375, 9'd275, 9'd200, 9'd150};

  typedef enum logic [1:0] {
    SELECCION = 2'd0,
    GIRANDO   = 2'd1,
    PAUSA     = 2'd2,
    FIN       = 2'd3
  } estado_t;

endpackage

// File: rtl/centrifugado_programable_if.sv
// Front-panel / motor-side signal bundle of the spin controller.
// The master side is the panel and top FSM; the slave side is the controller.
interface centrifugado_programable_if #(
  parameter int NUM_NIVELES = 4,
  parameter int ANCHO_SEG   = 9
);
  localparam int ANCHO_NIV = (NUM_NIVELES > 1) ? $clog2(NUM_NIVELES) : 1;

  logic                   iBoton_TiempoCentri;
  logic                   iHabilitar;
  logic                   iTick_1Hz;
  logic                   iStart;
  logic                   iPausa;
  logic [NUM_NIVELES-1:0] iLed_Centri;
  logic [ANCHO_NIV-1:0]   iNivel;
  logic                   iNivel_Valido;
  logic [ANCHO_SEG-1:0]   iSegundos_Restantes;
  logic                   iMotor_Centri;
  logic                   iFin_Centri;
  logic [1:0]             iEstado;

  modport master (
    output iBoton_TiempoCentri, iHabilitar, iTick_1Hz, iStart, iPausa,
    input  iLed_Centri, iNivel, iNivel_Valido, iSegundos_Restantes,
           iMotor_Centri, iFin_Centri, iEstado
  );

  modport slave (
    input  iBoton_TiempoCentri, iHabilitar, iTick_1Hz, iStart, iPausa,
    output iLed_Centri, iNivel, iNivel_Valido, iSegundos_Restantes,
           iMotor_Centri, iFin_Centri, iEstado
  );

endinterface

// File: rtl/detector_flanco.sv
// Two-flop synchronizer for an asynchronous button followed by a
// rising-edge detector; a held button yields a single one-cycle pulse.
module detector_flanco (
  input  logic clk_in,
  input  logic iEncender,
  input  logic boton_i,
  output logic pulso_o
);

  logic sinc1_q, sinc2_q, prev_q;

  always_ff @(posedge clk_in or negedge iEncender) begin
    if (!iEncender) begin
      sinc1_q <= 1'b0;
      sinc2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sinc1_q <= boton_i;
      sinc2_q <= sinc1_q;
      prev_q  <= sinc2_q;
    end
  end

  assign pulso_o = sinc2_q & ~prev_q;

endmodule

// File: rtl/centrifugado_programable.sv
// Spin-cycle controller: button-driven level selection, then a 1 Hz
// countdown with pause/abort that drives the spin motor enable.
//
// state     | meaning
// SELECCION | choosing a level; button steps level, start loads countdown
// GIRANDO   | motor on, counting down on each 1 Hz tick
// PAUSA     | motor off, countdown frozen until pause is released
// FIN       | single-cycle completion pulse, then back to selection
module centrifugado_programable
  import lavadora_pkg::*;
#(
  parameter int NUM_NIVELES = NUM_NIVELES_DEF,
  parameter int ANCHO_SEG   = ANCHO_SEG_DEF,
  parameter logic [NUM_NIVELES*ANCHO_SEG-1:0] TIEMPOS = TIEMPOS_DEF
) (
  input  logic                        clk_in,
  input  logic                        iEncender,
  centrifugado_programable_if.slave   bus
);

  localparam int ANCHO_NIV = (NUM_NIVELES > 1) ? $clog2(NUM_NIVELES) : 1;
  localparam logic [ANCHO_NIV-1:0] NIV_MAX = ANCHO_NIV'(NUM_NIVELES - 1);

  function automatic logic [ANCHO_SEG-1:0] tiempo(input logic [ANCHO_NIV-1:0] n);
    return TIEMPOS[ANCHO_SEG*int'(n) +: ANCHO_SEG];
  endfunction

  logic pulso_boton;

  detector_flanco u_boton (
    .clk_in    (clk_in),
    .iEncender (iEncender),
    .boton_i   (bus.iBoton_TiempoCentri),
    .pulso_o   (pulso_boton)
  );

  estado_t                estado_q, estado_d;
  logic [ANCHO_NIV-1:0]   nivel_q, nivel_d;
  logic                   valido_q, valido_d;
  logic [ANCHO_SEG-1:0]   seg_q, seg_d;
  logic [NUM_NIVELES-1:0] led_q, led_d;
  logic                   motor_q, fin_q;

  always_comb begin
    estado_d = estado_q;
    nivel_d  = nivel_q;
    valido_d = valido_q;
    seg_d    = seg_q;
    case (estado_q)
      SELECCION: begin
        if (!bus.iHabilitar) begin
          valido_d = 1'b0;
          nivel_d  = '0;
        end else if (bus.iStart && valido_q) begin
          estado_d = GIRANDO;
        end else if (pulso_boton) begin
          if (!valido_q) begin
            valido_d = 1'b1;
            nivel_d  = '0;
          end else begin
            nivel_d = (nivel_q == NIV_MAX) ? '0 : nivel_q + ANCHO_NIV'(1);
          end
        end
        // Shows the selected duration; on start this is the countdown load.
        seg_d = valido_d ? tiempo(nivel_d) : '0;
      end
      GIRANDO: begin
        if (!bus.iHabilitar) begin
          estado_d = SELECCION;
          valido_d = 1'b0;
          nivel_d  = '0;
          seg_d    = '0;
        end else if (bus.iPausa) begin
          estado_d = PAUSA;
        end else if (seg_q == '0) begin
          estado_d = FIN;
        end else if (bus.iTick_1Hz) begin
          seg_d = seg_q - ANCHO_SEG'(1);
          if (seg_q == ANCHO_SEG'(1)) estado_d = FIN;
        end
      end
      PAUSA: begin
        if (!bus.iHabilitar) begin
          estado_d = SELECCION;
          valido_d = 1'b0;
          nivel_d  = '0;
          seg_d    = '0;
        end else if (!bus.iPausa) begin
          estado_d = GIRANDO;
        end
      end
      FIN: begin
        estado_d = SELECCION;
        seg_d    = tiempo(nivel_q);
      end
      default: estado_d = SELECCION;
    endcase
    led_d = '0;
    if (valido_d) led_d[nivel_d] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge iEncender) begin
    if (!iEncender) begin
      estado_q <= SELECCION;
      nivel_q  <= '0;
      valido_q <= 1'b0;
      seg_q    <= '0;
      led_q    <= '0;
      motor_q  <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      nivel_q  <= nivel_d;
      valido_q <= valido_d;
      seg_q    <= seg_d;
      led_q    <= led_d;
      // Motor lags entry into GIRANDO by a cycle but drops on the same edge it leaves.
      motor_q  <= (estado_q == GIRANDO) && (estado_d == GIRANDO);
      fin_q    <= (estado_d == FIN);
    end
  end

  assign bus.iEstado             = estado_q;
  assign bus.iNivel              = nivel_q;
  assign bus.iNivel_Valido       = valido_q;
  assign bus.iSegundos_Restantes = seg_q;
  assign bus.iLed_Centri         = led_q;
  assign bus.iMotor_Centri       = motor_q;
  assign bus.iFin_Centri         = fin_q;

endmodule
